// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: WB control bit positions, SP reset value, GPR geometry.
package wb_regfile_pkg;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int REG_W    = 16;

  localparam logic [31:0] SP_RESET = 32'h000F_FFFF;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: write-back controls and data in, decode read ports, SP and debug counter out.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int WbSize = 2
);
  logic                enable;
  logic [WbSize-1:0]   i_WB;
  logic [31:0]         i_MemData;
  logic [REG_W-1:0]    i_alu;
  logic [REG_AW-1:0]   i_Rdst;
  logic [31:0]         i_SP;
  logic                i_SpWe;
  logic [REG_AW-1:0]   i_Rsrc1;
  logic [REG_AW-1:0]   i_Rsrc2;
  logic [REG_W-1:0]    o_Rdata1;
  logic [REG_W-1:0]    o_Rdata2;
  logic [31:0]         o_SP;
  logic [REG_W-1:0]    o_WbData;
  logic [31:0]         o_WbCount;

  modport master (
    output enable, i_WB, i_MemData, i_alu, i_Rdst, i_SP, i_SpWe, i_Rsrc1, i_Rsrc2,
    input  o_Rdata1, o_Rdata2, o_SP, o_WbData, o_WbCount
  );

  modport slave (
    input  enable, i_WB, i_MemData, i_alu, i_Rdst, i_SP, i_SpWe, i_Rsrc1, i_Rsrc2,
    output o_Rdata1, o_Rdata2, o_SP, o_WbData, o_WbCount
  );

endinterface

// File: rtl/wb_mux.sv
// Write-back data select: memory load low half or ALU result. Purely combinational, reused by forwarding.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int RegWidth = REG_W
) (
  input  logic                i_mem_to_reg,
  input  logic [31:0]         i_MemData,
  input  logic [RegWidth-1:0] i_alu,
  output logic [RegWidth-1:0] o_WbData
);

  // Loads write back only the low half; the upper bits are deliberately dropped.
  logic w_unused_mem_hi;
  assign w_unused_mem_hi = ^i_MemData[31:RegWidth];

  assign o_WbData = i_mem_to_reg ? i_MemData[RegWidth-1:0] : i_alu;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: 8x16 GPR file, SP and GPR write counter, with two bypassed combinational read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int          WbSize   = 2,
  parameter int          NumRegs  = NUM_REGS,
  parameter int          RegWidth = REG_W,
  parameter logic [31:0] SpReset  = SP_RESET
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [RegWidth-1:0] r_gpr [NumRegs];
  logic [31:0]         r_sp;
  logic [31:0]         r_wb_cnt;

  logic [RegWidth-1:0] w_wb_dat;
  logic                w_gpr_we;
  logic                w_byp_en;
  logic                w_byp1;
  logic                w_byp2;

  generate
    if (WbSize > 2) begin : g_wb_hi
      logic w_unused_wb_hi;
      assign w_unused_wb_hi = ^bus.i_WB[WbSize-1:2];
    end
  endgenerate

  wb_mux #(
    .RegWidth (RegWidth)
  ) u_wb_mux (
    .i_mem_to_reg (bus.i_WB[WB_MEMTOREG]),
    .i_MemData    (bus.i_MemData),
    .i_alu        (bus.i_alu),
    .o_WbData     (w_wb_dat)
  );

  assign w_gpr_we = bus.enable & bus.i_WB[WB_REGWRITE];

  // Bypass must not leak write data onto the read ports while reset is held.
  assign w_byp_en = rst & w_gpr_we;
  assign w_byp1   = w_byp_en && (bus.i_Rsrc1 == bus.i_Rdst);
  assign w_byp2   = w_byp_en && (bus.i_Rsrc2 == bus.i_Rdst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_gpr_we) begin
      r_gpr[bus.i_Rdst] <= w_wb_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= SpReset;
    end else if (bus.enable && bus.i_SpWe) begin
      r_sp <= bus.i_SP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_cnt <= '0;
    end else if (w_gpr_we) begin
      r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign bus.o_Rdata1  = w_byp1 ? w_wb_dat : r_gpr[bus.i_Rsrc1];
  assign bus.o_Rdata2  = w_byp2 ? w_wb_dat : r_gpr[bus.i_Rsrc2];
  assign bus.o_WbData  = w_wb_dat;
  assign bus.o_SP      = r_sp;
  assign bus.o_WbCount = r_wb_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus random stimulus against a behavioural register-file model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst;

  wb_regfile_if #(.WbSize(2)) bus ();

  wb_regfile u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_gpr [8];
  logic [31:0] m_sp;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_gpr[i] = 16'h0;
    m_sp  = 32'h000F_FFFF;
    m_cnt = 32'h0;
  endtask

  function automatic logic [15:0] m_wb();
    return bus.i_WB[1] ? bus.i_MemData[15:0] : bus.i_alu;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] addr);
    if (!rst) return 16'h0;
    if (bus.enable && bus.i_WB[0] && addr == bus.i_Rdst) return m_wb();
    return m_gpr[addr];
  endfunction

  task automatic drive(input logic en, input logic [1:0] wb, input logic [31:0] mem,
                       input logic [15:0] alu, input logic [2:0] rdst, input logic [31:0] sp,
                       input logic spwe, input logic [2:0] rs1, input logic [2:0] rs2);
    bus.enable    = en;
    bus.i_WB      = wb;
    bus.i_MemData = mem;
    bus.i_alu     = alu;
    bus.i_Rdst    = rdst;
    bus.i_SP      = sp;
    bus.i_SpWe    = spwe;
    bus.i_Rsrc1   = rs1;
    bus.i_Rsrc2   = rs2;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 16'($urandom), 3'($urandom),
          $urandom, 1'($urandom), 3'($urandom), 3'($urandom));
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".wbdata"}, {16'h0, bus.o_WbData}, {16'h0, m_wb()});
    check({tag, ".rdata1"}, {16'h0, bus.o_Rdata1}, {16'h0, m_read(bus.i_Rsrc1)});
    check({tag, ".rdata2"}, {16'h0, bus.o_Rdata2}, {16'h0, m_read(bus.i_Rsrc2)});
    check({tag, ".sp"},     bus.o_SP,      m_sp);
    check({tag, ".count"},  bus.o_WbCount, m_cnt);
  endtask

  // Called between a falling edge and the next rising edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    check_comb(tag);
    @(posedge clk);
    if (rst && bus.enable) begin
      if (bus.i_WB[0]) begin
        m_gpr[bus.i_Rdst] = m_wb();
        m_cnt = m_cnt + 32'd1;
      end
      if (bus.i_SpWe) m_sp = bus.i_SP;
    end
    #1;
    check({tag, ".post_sp"},    bus.o_SP,      m_sp);
    check({tag, ".post_count"}, bus.o_WbCount, m_cnt);
    @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b01, $urandom, 16'($urandom), 3'($urandom), $urandom, 1'b1, 3'(i), 3'(7 - i));
      step(tag);
    end
  endtask

  initial begin
    rst = 1'b0;
    m_reset();
    drive_rand();

    // 1. reset held with random inputs, then release and read everything
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'($urandom), $urandom, 16'($urandom), 3'($urandom), $urandom, 1'b1,
            3'($urandom), 3'($urandom));
      bus.i_Rsrc1 = bus.i_Rdst;
      step("reset_hold");
    end
    rst = 1'b1;
    read_all("after_reset");

    // 2. ALU write with bypass
    drive(1'b1, 2'b01, 32'hFFFF_0000, 16'hBEEF, 3'd3, 32'h0, 1'b0, 3'd3, 3'd0);
    step("alu_write");
    check("alu_r3_fixed", {16'h0, m_gpr[3]}, 32'h0000_BEEF);
    check("alu_count_fixed", bus.o_WbCount, 32'd1);

    // 3. memory write, upper half discarded
    drive(1'b1, 2'b11, 32'h1234_ABCD, 16'h5555, 3'd7, 32'h0, 1'b0, 3'd7, 3'd3);
    step("mem_write");
    drive(1'b0, 2'b00, 32'h0, 16'h0, 3'd0, 32'h0, 1'b0, 3'd7, 3'd3);
    #1;
    check("mem_r7_fixed", {16'h0, bus.o_Rdata1}, 32'h0000_ABCD);
    step("mem_readback");

    // 4. enable low: no writes, no bypass
    drive(1'b0, 2'b01, 32'h0, 16'h1111, 3'd3, 32'h0000_1234, 1'b1, 3'd3, 3'd3);
    #1;
    check("gate_nobypass_fixed", {16'h0, bus.o_Rdata1}, 32'h0000_BEEF);
    step("gated");
    check("gate_sp_fixed", bus.o_SP, 32'h000F_FFFF);

    // 5. simultaneous GPR and SP write, both ports hit bypass
    drive(1'b1, 2'b01, 32'h0, 16'hC0DE, 3'd2, 32'h000F_FFFD, 1'b1, 3'd2, 3'd2);
    step("simul");
    check("simul_sp_fixed", bus.o_SP, 32'h000F_FFFD);
    drive(1'b0, 2'b00, 32'h0, 16'h0, 3'd0, 32'h0, 1'b0, 3'd2, 3'd2);
    step("simul_readback");

    // consecutive writes to one register: last wins
    drive(1'b1, 2'b01, 32'h0, 16'hAAAA, 3'd5, 32'h0, 1'b0, 3'd0, 3'd1);
    step("consec1");
    drive(1'b1, 2'b11, 32'h9999_7777, 16'h0, 3'd5, 32'h0, 1'b0, 3'd0, 3'd1);
    step("consec2");
    drive(1'b0, 2'b00, 32'h0, 16'h0, 3'd0, 32'h0, 1'b0, 3'd5, 3'd5);
    #1;
    check("consec_last_fixed", {16'h0, bus.o_Rdata1}, 32'h0000_7777);
    step("consec_read");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive_rand();
      step("random");
    end

    // 6. asynchronous reset between edges with a write pending
    drive(1'b1, 2'b01, 32'h0, 16'h4242, 3'd4, 32'h0000_0100, 1'b1, 3'd4, 3'd7);
    #2;
    rst = 1'b0;
    m_reset();
    step("async_reset");
    check("async_count_fixed", bus.o_WbCount, 32'd0);
    rst = 1'b1;
    read_all("after_async_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
